pwm_fader: RTL and testbench
============================

Name: pwm_fader

Overview:
- Upstream companion of the PWM stage; drives that stage's pulse-width input.
- Ramps the duty cycle from its current value to a commanded target, in programmable steps, every N PWM periods (LED breathing/fading).
- Runs a period counter that is reset together with, and stays lock-stepped to, the PWM stage counter.
- Changes the duty value only at period boundaries, so the PWM stage never sees a mid-period change.

Parameters:
- CtrSize, 8: width of duty value and period counter; one PWM period = 2^CtrSize cycles.
- IntervalSize, 16: width of the periods-per-step interval field.

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_i  input  1  synchronous, active-high reset.
- cmd_valid_i  input  1  fade command valid.
- cmd_ready_o  output  1  fader can accept a command.
- cmd_target_i  input  CtrSize  target duty.
- cmd_step_i  input  CtrSize  duty change per step; 0 is treated as 1.
- cmd_interval_i  input  IntervalSize  PWM periods per step; 0 is treated as 1.
- abort_i  input  1  stop ramp and hold current duty.
- pulse_width_o  output  CtrSize  duty value to the PWM stage.
- period_tick_o  output  1  high in the last cycle of each period (counter = all ones).
- busy_o  output  1  ramp in progress.
- done_o  output  1  one-cycle pulse when the target is reached.

Behaviour:
- Clock and reset:
  - Single clock domain; reset sampled on clk_sys_i while rst_sys_i = 1.
  - Reset values: counter 0, pulse_width_o 0, FSM IDLE, busy_o 0, done_o 0, cmd_ready_o 1.
  - Reset mid-ramp discards the ramp immediately.
- Period counter:
  - CtrSize bits; increments every cycle and wraps 2^CtrSize-1 -> 0.
  - period_tick_o is combinational: (counter == all ones).
- Duty register:
  - Drives pulse_width_o; written only in a tick cycle.
  - A new value is visible in the cycle where counter = 0.
- FSM, 2 states:
  - IDLE: cmd_ready_o = 1. On cmd_valid_i && cmd_ready_o, latch target, step (0 -> 1) and interval (0 -> 1); load the interval down-counter with the interval.
    - If target == current duty: stay IDLE; done_o pulses the next cycle; busy_o stays 0.
    - Otherwise go to RAMP.
  - RAMP: busy_o = 1, cmd_ready_o = 0; cmd_valid_i is stalled and not dropped.
    - On each tick, decrement the interval counter. When it reaches 0, apply one step and reload the interval.
    - Up-step: duty = min(duty + step, target), computed in CtrSize+1 bits; never wraps.
    - Down-step: duty = max(duty - step, target), computed signed or with a compare; never underflows.
    - If the updated duty equals the target: go to IDLE, and assert done_o in the same cycle as the final update (registered). cmd_ready_o returns 1 in the cycle after.
- Step timing: the first step occurs on the interval-th tick after acceptance. A command accepted in a tick cycle counts ticks from the next one.
- abort_i:
  - In RAMP: go to IDLE the next cycle; duty holds; no done_o.
  - In IDLE: no effect.
  - abort_i in the same cycle as a final-step tick: the step applies and done_o fires (completion wins).
- Simultaneous cmd_valid_i and abort_i in IDLE: the command is accepted.
- cmd_* fields are sampled only on a handshake; later changes are ignored.

Decomposition:
- Package pwm_pkg:
  - fader_state_e {FaderIdle, FaderRamp}.
  - Default width constants PwmCtrSize = 8 and PwmIntervalSize = 16.
- Sub-module pwm_period_ctr: period counter plus tick output. Reused by a future shared-counter PWM top so that both stages share one counter.

Test Plan (CtrSize = 4, period 16 cycles):
- Reset: hold rst_sys_i 3 cycles mid-ramp -> next cycle pulse_width_o = 0, busy_o = 0, cmd_ready_o = 1, counter = 0.
- Ramp up from 0: target 10, step 3, interval 1 -> pulse_width_o = 3, 6, 9, 10 at counter = 0 of four consecutive periods; done_o high one cycle with the 10 update; cmd_ready_o high the cycle after.
- Ramp down from 10: target 2, step 4, interval 2 -> 6 after 2 periods, 2 after 4 periods, then done_o. Also: cmd_valid_i held during the ramp -> not accepted until IDLE.
- Saturation and zero fields:
  - From 2, target 15, step 15, interval 0 -> 15 after 1 period; no wrap.
  - From 15, target 0, step 0 -> decrements by 1 each period.
- No-op command: from 7, target 7 -> busy_o never rises; done_o pulses next cycle; pulse_width_o stays 7.
- Abort: abort_i during a ramp at duty 6 -> IDLE next cycle, pulse_width_o holds 6, no done_o. Also: abort_i on a final-step tick -> done_o fires.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM fader and its period counter.
package pwm_pkg;

  localparam int unsigned PwmCtrSize      = 8;
  localparam int unsigned PwmIntervalSize = 16;

  typedef enum logic {
    FaderIdle,
    FaderRamp
  } fader_state_e;

endpackage

// File: rtl/pwm_period_ctr.sv
// Free-running PWM period counter with a last-cycle-of-period tick.
module pwm_period_ctr
  import pwm_pkg::*;
#(
  parameter int unsigned CtrSize = PwmCtrSize
) (
  input  logic clk_sys_i,
  input  logic rst_sys_i,
  output logic tick_o
);

  logic [CtrSize-1:0] ctr_q;
  logic [CtrSize-1:0] ctr_d;

  always_comb begin
    ctr_d = ctr_q + CtrSize'(1);
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign tick_o = (ctr_q == '1);

endmodule

// File: rtl/pwm_fader.sv
// Ramps the PWM duty toward a commanded target in steps every N periods,
// updating the duty only at period boundaries.
module pwm_fader
  import pwm_pkg::*;
#(
  parameter int unsigned CtrSize      = PwmCtrSize,
  parameter int unsigned IntervalSize = PwmIntervalSize
) (
  input  logic                    clk_sys_i,
  input  logic                    rst_sys_i,
  input  logic                    cmd_valid_i,
  output logic                    cmd_ready_o,
  input  logic [CtrSize-1:0]      cmd_target_i,
  input  logic [CtrSize-1:0]      cmd_step_i,
  input  logic [IntervalSize-1:0] cmd_interval_i,
  input  logic                    abort_i,
  output logic [CtrSize-1:0]      pulse_width_o,
  output logic                    period_tick_o,
  output logic                    busy_o,
  output logic                    done_o
);

  logic tick;

  pwm_period_ctr #(.CtrSize(CtrSize)) u_period_ctr (
    .clk_sys_i (clk_sys_i),
    .rst_sys_i (rst_sys_i),
    .tick_o    (tick)
  );

  assign period_tick_o = tick;

  fader_state_e            state_q, state_d;
  logic [CtrSize-1:0]      duty_q, duty_d;
  logic [CtrSize-1:0]      target_q, target_d;
  logic [CtrSize-1:0]      step_q, step_d;
  logic [IntervalSize-1:0] interval_q, interval_d;
  logic [IntervalSize-1:0] icnt_q, icnt_d;
  logic                    up_q, up_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;

  // Candidate next duty, clamped at the target in both directions.
  logic [CtrSize:0]   up_sum;
  logic [CtrSize-1:0] down_gap;
  logic [CtrSize-1:0] next_duty;

  always_comb begin
    up_sum   = {1'b0, duty_q} + {1'b0, step_q};
    down_gap = duty_q - target_q;
    if (up_q) begin
      next_duty = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[CtrSize-1:0];
    end else begin
      next_duty = (down_gap <= step_q) ? target_q : duty_q - step_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    icnt_d     = icnt_q;
    up_d       = up_q;
    done_d     = 1'b0;

    case (state_q)
      FaderIdle: begin
        if (cmd_valid_i && ready_q) begin
          target_d   = cmd_target_i;
          step_d     = (cmd_step_i == '0) ? CtrSize'(1) : cmd_step_i;
          interval_d = (cmd_interval_i == '0) ? IntervalSize'(1) : cmd_interval_i;
          icnt_d     = interval_d;
          up_d       = (cmd_target_i > duty_q);
          if (cmd_target_i == duty_q) begin
            done_d = 1'b1;
          end else begin
            state_d = FaderRamp;
          end
        end
      end
      FaderRamp: begin
        if (tick) begin
          if (icnt_q == IntervalSize'(1)) begin
            icnt_d = interval_q;
            // Completion outranks a coincident abort; otherwise abort freezes duty.
            if (next_duty == target_q) begin
              duty_d  = next_duty;
              done_d  = 1'b1;
              state_d = FaderIdle;
            end else if (!abort_i) begin
              duty_d = next_duty;
            end
          end else begin
            icnt_d = icnt_q - IntervalSize'(1);
          end
        end
        if (abort_i && !done_d) begin
          state_d = FaderIdle;
        end
      end
      default: state_d = FaderIdle;
    endcase

    busy_d  = (state_d == FaderRamp);
    ready_d = (state_d == FaderIdle);
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      state_q    <= FaderIdle;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= CtrSize'(1);
      interval_q <= IntervalSize'(1);
      icnt_q     <= IntervalSize'(1);
      up_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      icnt_q     <= icnt_d;
      up_q       <= up_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
    end
  end

  assign pulse_width_o = duty_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign cmd_ready_o   = ready_q;

endmodule

// File: tb/tb_pwm_fader.sv
// Directed bench for pwm_fader with a 4-bit counter (16-cycle PWM period).
module tb_pwm_fader;

  localparam int unsigned CW = 4;
  localparam int unsigned IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_target;
  logic [CW-1:0] cmd_step;
  logic [IW-1:0] cmd_interval;
  logic          abort;
  logic [CW-1:0] pw;
  logic          tick;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pwm_fader #(.CtrSize(CW), .IntervalSize(IW)) dut (
    .clk_sys_i      (clk),
    .rst_sys_i      (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_target_i   (cmd_target),
    .cmd_step_i     (cmd_step),
    .cmd_interval_i (cmd_interval),
    .abort_i        (abort),
    .pulse_width_o  (pw),
    .period_tick_o  (tick),
    .busy_o         (busy),
    .done_o         (done)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Advance to the next tick cycle, bounded to a little over two periods.
  task automatic wait_tick(input string name);
    int n = 0;
    while (!tick && n < 40) begin
      cyc();
      n++;
    end
    total++;
    if (tick !== 1'b1) begin
      bad++;
      $display("FAIL %s tick_timeout got=%b want=1", name, tick);
    end
  endtask

  // One-cycle command; fields are scrambled afterwards to prove they are latched.
  task automatic send(input logic [CW-1:0] t, input logic [CW-1:0] s, input logic [IW-1:0] iv);
    cmd_valid    = 1'b1;
    cmd_target   = t;
    cmd_step     = s;
    cmd_interval = iv;
    cyc();
    cmd_valid    = 1'b0;
    cmd_target   = ~t;
    cmd_step     = ~s;
    cmd_interval = ~iv;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    total++; if (pw !== 4'd0)     begin bad++; $display("FAIL reset_pw got=%0d want=0", pw); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL reset_done got=%b want=0", done); end
    send(4'd10, 4'd5, 8'd1);
    wait_tick("reset_ramp");
    cyc();
    total++; if (pw !== 4'd5) begin bad++; $display("FAIL reset_preramp_pw got=%0d want=5", pw); end
    rst = 1'b1;
    cyc(); cyc(); cyc();
    rst = 1'b0;
    total++; if (pw !== 4'd0)     begin bad++; $display("FAIL midramp_reset_pw got=%0d want=0", pw); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL midramp_reset_busy got=%b want=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midramp_reset_ready got=%b want=1", cmd_ready); end
    total++; if (tick !== 1'b0)   begin bad++; $display("FAIL midramp_reset_tick got=%b want=0", tick); end
    for (int i = 0; i < 14; i++) cyc();
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL ctr14_tick got=%b want=0", tick); end
    cyc();
    total++; if (tick !== 1'b1) begin bad++; $display("FAIL ctr15_tick got=%b want=1", tick); end
  endtask

  task automatic test_ramp_up();
    logic [CW-1:0] exp_v [4] = '{4'd3, 4'd6, 4'd9, 4'd10};
    logic [CW-1:0] prev = 4'd0;
    send(4'd10, 4'd3, 8'd1);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL up_ready_busy got=%b want=0", cmd_ready); end
    total++; if (busy !== 1'b1)      begin bad++; $display("FAIL up_busy got=%b want=1", busy); end
    for (int i = 0; i < 4; i++) begin
      wait_tick("up");
      total++; if (pw !== prev) begin bad++; $display("FAIL up_hold[%0d] got=%0d want=%0d", i, pw, prev); end
      cyc();
      total++; if (pw !== exp_v[i]) begin bad++; $display("FAIL up_pw[%0d] got=%0d want=%0d", i, pw, exp_v[i]); end
      total++; if (done !== (i == 3)) begin bad++; $display("FAIL up_done[%0d] got=%b want=%b", i, done, (i == 3)); end
      prev = exp_v[i];
    end
    cyc();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL up_ready_after got=%b want=1", cmd_ready); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL up_done_pulse got=%b want=0", done); end
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL up_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_ramp_down();
    logic [CW-1:0] exp_v [4] = '{4'd10, 4'd6, 4'd6, 4'd2};
    send(4'd2, 4'd4, 8'd2);
    // Held command must wait for the ramp to finish.
    cmd_valid = 1'b1; cmd_target = 4'd12; cmd_step = 4'd5; cmd_interval = 8'd1;
    for (int i = 0; i < 4; i++) begin
      wait_tick("down");
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL down_stall[%0d] got=%b want=0", i, cmd_ready); end
      cyc();
      total++; if (pw !== exp_v[i]) begin bad++; $display("FAIL down_pw[%0d] got=%0d want=%0d", i, pw, exp_v[i]); end
      total++; if (done !== (i == 3)) begin bad++; $display("FAIL down_done[%0d] got=%b want=%b", i, done, (i == 3)); end
    end
    cyc();
    cmd_valid = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL held_cmd_accept got=%b want=1", busy); end
    wait_tick("held1");
    cyc();
    total++; if (pw !== 4'd7) begin bad++; $display("FAIL held_pw1 got=%0d want=7", pw); end
    wait_tick("held2");
    cyc();
    total++; if (pw !== 4'd12) begin bad++; $display("FAIL held_pw2 got=%0d want=12", pw); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done got=%b want=1", done); end
  endtask

  task automatic test_saturation_abort();
    logic saw_done = 1'b0;
    logic pw_moved = 1'b0;
    send(4'd2, 4'd15, 8'd1);
    wait_tick("sat_down");
    cyc();
    total++; if (pw !== 4'd2) begin bad++; $display("FAIL sat_down_pw got=%0d want=2", pw); end
    send(4'd15, 4'd15, 8'd0);
    wait_tick("sat_up");
    cyc();
    total++; if (pw !== 4'd15) begin bad++; $display("FAIL sat_up_pw got=%0d want=15", pw); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sat_up_done got=%b want=1", done); end
    send(4'd0, 4'd0, 8'd1);
    for (int v = 14; v >= 6; v--) begin
      wait_tick("step0");
      cyc();
      total++; if (pw !== CW'(v)) begin bad++; $display("FAIL step0_pw got=%0d want=%0d", pw, v); end
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", cmd_ready); end
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      if (pw !== 4'd6) pw_moved = 1'b1;
      cyc();
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort_no_done got=%b want=0", saw_done); end
    total++; if (pw_moved !== 1'b0) begin bad++; $display("FAIL abort_hold got=%0d want=6", pw); end
  endtask

  task automatic test_noop();
    logic busy_seen = 1'b0;
    send(4'd7, 4'd1, 8'd1);
    wait_tick("to7");
    cyc();
    total++; if (pw !== 4'd7) begin bad++; $display("FAIL to7_pw got=%0d want=7", pw); end
    send(4'd7, 4'd3, 8'd4);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL noop_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL noop_busy got=%b want=0", busy); end
    cyc();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL noop_done_pulse got=%b want=0", done); end
    for (int i = 0; i < 20; i++) begin
      if (busy) busy_seen = 1'b1;
      cyc();
    end
    total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL noop_busy_seen got=%b want=0", busy_seen); end
    total++; if (pw !== 4'd7) begin bad++; $display("FAIL noop_pw got=%0d want=7", pw); end
  endtask

  task automatic test_abort_final();
    send(4'd9, 4'd2, 8'd1);
    wait_tick("abort_final");
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    total++; if (pw !== 4'd9)   begin bad++; $display("FAIL abort_final_pw got=%0d want=9", pw); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL abort_final_done got=%b want=1", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_final_busy got=%b want=0", busy); end
    // Abort while idle must not block a simultaneous command.
    abort = 1'b1;
    send(4'd11, 4'd2, 8'd1);
    abort = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL idle_abort_cmd got=%b want=1", busy); end
    wait_tick("idle_abort_ramp");
    cyc();
    total++; if (pw !== 4'd11)  begin bad++; $display("FAIL idle_abort_pw got=%0d want=11", pw); end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL idle_abort_done got=%b want=1", done); end
  endtask

  initial begin
    rst          = 1'b1;
    cmd_valid    = 1'b0;
    cmd_target   = '0;
    cmd_step     = '0;
    cmd_interval = '0;
    abort        = 1'b0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_saturation_abort();
    test_noop();
    test_abort_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
